// File: rtl/adc_capture_if.sv
// Bus between the ADC capture block and its controller / sample consumer.
// dvalid is a one-cycle strobe with no ready: the consumer must take dataout on every cycle dvalid is high.
interface adc_capture_if #(
  parameter int DW   = 12,
  parameter int CH   = 2,
  parameter int DECW = 8
);
  logic              en;
  logic              fmt;
  logic [DECW-1:0]   dec;
  logic              ovr_clr;
  logic [CH*DW-1:0]  datain;
  logic [CH*DW-1:0]  dataout;
  logic              dvalid;
  logic [CH-1:0]     ovr;

  modport master (
    output en, fmt, dec, ovr_clr, datain,
    input  dataout, dvalid, ovr
  );

  modport slave (
    input  en, fmt, dec, ovr_clr, datain,
    output dataout, dvalid, ovr
  );
endinterface

// File: rtl/adc_capture.sv
// Multi-channel ADC capture: falling-edge latch, rising-edge retime, optional
// offset-binary to two's complement, runtime decimation and sticky overrange flags.
module adc_capture #(
  parameter int DW   = 12,
  parameter int CH   = 2,
  parameter int DECW = 8
) (
  input  logic           clk,
  input  logic           rst,
  adc_capture_if.slave   bus
);

  logic [CH*DW-1:0] n_q;
  logic [CH*DW-1:0] fmt_data;
  logic [CH-1:0]    or_det;
  logic [CH*DW-1:0] r1_data;
  logic             r1_v;
  logic [CH-1:0]    r1_or;
  logic [DECW-1:0]  cnt;
  logic [CH*DW-1:0] dataout_q;
  logic             dvalid_q;
  logic [CH-1:0]    ovr_q;

  // ADC launches on the rising edge, so the bus is stable around the falling edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) n_q <= '0;
    else     n_q <= bus.datain;
  end

  always_comb begin
    fmt_data = n_q;
    or_det   = '0;
    for (int c = 0; c < CH; c++) begin
      if (bus.fmt) fmt_data[c*DW + DW - 1] = ~n_q[c*DW + DW - 1];
      or_det[c] = (n_q[c*DW +: DW] == {DW{1'b1}}) || (n_q[c*DW +: DW] == {DW{1'b0}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_data <= '0;
      r1_v    <= 1'b0;
      r1_or   <= '0;
    end else begin
      r1_data <= fmt_data;
      r1_v    <= bus.en;
      r1_or   <= or_det;
    end
  end

  // >= rather than == so lowering dec below the running count wraps on the next sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      dataout_q <= '0;
      dvalid_q  <= 1'b0;
    end else if (!r1_v) begin
      cnt      <= '0;
      dvalid_q <= 1'b0;
    end else if (cnt >= bus.dec) begin
      cnt       <= '0;
      dataout_q <= r1_data;
      dvalid_q  <= 1'b1;
    end else begin
      cnt      <= cnt + {{(DECW-1){1'b0}}, 1'b1};
      dvalid_q <= 1'b0;
    end
  end

  // Flags see every valid sample, decimated or not; a set beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_q <= '0;
    else     ovr_q <= (ovr_q & ~{CH{bus.ovr_clr}}) | ({CH{r1_v}} & r1_or);
  end

  assign bus.dataout = dataout_q;
  assign bus.dvalid  = dvalid_q;
  assign bus.ovr     = ovr_q;

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: table-driven format vectors, hand-written
// decimation / enable / overrange / reset sequences and a randomized run against a sample-level model.
module tb_adc_capture;
  localparam int DW   = 12;
  localparam int CH   = 2;
  localparam int DECW = 8;
  localparam int HN   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_capture_if #(.DW(DW), .CH(CH), .DECW(DECW)) bus ();

  adc_capture #(.DW(DW), .CH(CH), .DECW(DECW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Input history per cycle (inputs driven just after rising edge number cyc).
  logic [CH*DW-1:0] h_din [HN];
  logic             h_en  [HN];
  logic             h_fmt [HN];
  logic             h_clr [HN];
  logic [DECW-1:0]  h_dec [HN];

  // Model state.
  logic [CH*DW-1:0] m_dout;
  logic             m_dv;
  logic [CH-1:0]    m_ovr;
  int               m_pend;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  typedef struct packed {
    logic          fmt;
    logic [DW-1:0] in0;
    logic [DW-1:0] in1;
    logic [DW-1:0] ex0;
    logic [DW-1:0] ex1;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Two's complement of an offset-binary code is the code minus half scale.
  function automatic logic [CH*DW-1:0] conv(input logic [CH*DW-1:0] d, input logic f);
    logic [CH*DW-1:0] r;
    int x;
    r = d;
    if (f) begin
      for (int c = 0; c < CH; c++) begin
        x = int'(d[c*DW +: DW]) - (1 << (DW-1));
        r[c*DW +: DW] = x[DW-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [CH-1:0] ovr_of(input logic [CH*DW-1:0] d);
    logic [CH-1:0] o;
    int x;
    o = '0;
    for (int c = 0; c < CH; c++) begin
      x = int'(d[c*DW +: DW]);
      o[c] = (x == 0) || (x == (1 << DW) - 1);
    end
    return o;
  endfunction

  // Output seen after edge cyc belongs to the sample driven at cyc-2, with dec/clr driven at cyc-1.
  task automatic model_step();
    int s;
    logic v;
    logic clr;
    logic [DECW-1:0] d;
    s   = cyc - 2;
    v   = 1'b0;
    if (s >= 0) v = h_en[s];
    clr = h_clr[cyc-1];
    d   = h_dec[cyc-1];
    m_ovr = m_ovr & ~{CH{clr}};
    if (v) m_ovr = m_ovr | ovr_of(h_din[s]);
    if (!v) begin
      m_pend = 0;
      m_dv   = 1'b0;
    end else begin
      m_pend++;
      if (m_pend > int'(d)) begin
        m_dout = conv(h_din[s], h_fmt[s]);
        m_dv   = 1'b1;
        m_pend = 0;
      end else begin
        m_dv = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic e, input logic f, input logic [DECW-1:0] d,
                       input logic c, input logic [CH*DW-1:0] din);
    bus.en      = e;
    bus.fmt     = f;
    bus.dec     = d;
    bus.ovr_clr = c;
    bus.datain  = din;
    h_en[cyc]   = e;
    h_fmt[cyc]  = f;
    h_dec[cyc]  = d;
    h_clr[cyc]  = c;
    h_din[cyc]  = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    chk("dataout", bus.dataout, m_dout);
    chk("dvalid", bus.dvalid, m_dv);
    chk("ovr", bus.ovr, m_ovr);
    if (bus.dvalid) got_q.push_back(bus.dataout[DW-1:0]);
  endtask

  task automatic cmp_queues(input string nm);
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({nm, "_value"}, got_q[i], exp_q[i]);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovr  = '0;
    m_pend = 0;
    h_en[cyc] = 1'b0;
    if (cyc > 0) h_en[cyc-1] = 1'b0;
    chk("rst_async_dataout", bus.dataout, 0);
    chk("rst_async_dvalid", bus.dvalid, 0);
    chk("rst_async_ovr", bus.ovr, 0);
    repeat (n) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      step();
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input logic [DECW-1:0] d);
    repeat (n) begin
      drive(1'b0, 1'b0, d, 1'b0, {12'h0AA, 12'h0AA});
      step();
    end
  endtask

  initial begin : main
    logic [CH*DW-1:0] safe;
    logic [CH*DW-1:0] rd;
    logic             rf;
    safe = {12'h555, 12'h555};
    rf   = 1'b0;
    for (int i = 0; i < HN; i++) begin
      h_din[i] = '0; h_en[i] = 1'b0; h_fmt[i] = 1'b0; h_clr[i] = 1'b0; h_dec[i] = '0;
    end
    m_dout = '0; m_dv = 1'b0; m_ovr = '0; m_pend = 0;

    vt[0] = '{1'b1, 12'h800, 12'h123, 12'h000, 12'h923};
    vt[1] = '{1'b1, 12'hFFF, 12'h456, 12'h7FF, 12'hC56};
    vt[2] = '{1'b1, 12'h000, 12'h9AB, 12'h800, 12'h1AB};
    vt[3] = '{1'b1, 12'h7FF, 12'h7FF, 12'hFFF, 12'hFFF};
    vt[4] = '{1'b0, 12'h800, 12'h123, 12'h800, 12'h123};
    vt[5] = '{1'b0, 12'hFFF, 12'h456, 12'hFFF, 12'h456};
    vt[6] = '{1'b0, 12'h000, 12'h9AB, 12'h000, 12'h9AB};
    vt[7] = '{1'b0, 12'h7FF, 12'h001, 12'h7FF, 12'h001};

    // Reset state.
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    #1;
    chk("reset_dataout", bus.dataout, 0);
    chk("reset_dvalid", bus.dvalid, 0);
    chk("reset_ovr", bus.ovr, 0);
    step();
    step();
    rst = 1'b0;
    idle(2, '0);

    // Pass-through ramp, dec=0: output after iteration i is sample i-1.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0, {DW'(12'h100 + i), DW'(i)});
      step();
      if (i >= 1) begin
        chk("pt_dvalid", bus.dvalid, 1);
        chk("pt_data", bus.dataout, {DW'(12'h100 + i - 1), DW'(i - 1)});
      end
    end

    // Format table.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vt[i].fmt, '0, 1'b0, {vt[i].in1, vt[i].in0});
      step();
      drive(1'b1, vt[i].fmt, '0, 1'b0, {vt[i].in1, vt[i].in0});
      step();
      chk("fmt_ch0", bus.dataout[DW-1:0], vt[i].ex0);
      chk("fmt_ch1", bus.dataout[2*DW-1:DW], vt[i].ex1);
      chk("fmt_dvalid", bus.dvalid, 1);
    end

    // Decimation by 4.
    idle(2, 8'd3);
    got_q.delete();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, 8'd3, 1'b0, {12'h000, DW'(k)});
      step();
    end
    idle(2, 8'd3);
    exp_q = '{12'd3, 12'd7, 12'd11};
    cmp_queues("dec4");

    // Lower dec from 3 to 1 after two samples have been absorbed.
    got_q.delete();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b0, (k < 3) ? 8'd3 : 8'd1, 1'b0, {12'h000, DW'(100 + k)});
      step();
    end
    idle(2, 8'd1);
    exp_q = '{12'd102, 12'd104, 12'd106};
    cmp_queues("dec_lower");

    // Enable gap mid-count restarts decimation.
    idle(1, 8'd3);
    got_q.delete();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 8'd3, 1'b0, {12'h000, DW'(k)});
      step();
    end
    idle(5, 8'd3);
    for (int k = 10; k < 18; k++) begin
      drive(1'b1, 1'b0, 8'd3, 1'b0, {12'h000, DW'(k)});
      step();
    end
    idle(2, 8'd3);
    exp_q = '{12'd3, 12'd13, 12'd17};
    cmp_queues("en_gap");

    // Overrange flags.
    drive(1'b0, 1'b0, '0, 1'b1, safe); step();
    idle(3, '0);
    chk("ovr_cleared", bus.ovr, 2'b00);
    drive(1'b1, 1'b0, '0, 1'b0, {12'hFFF, 12'h555}); step();
    drive(1'b1, 1'b0, '0, 1'b0, safe); step();
    chk("ovr_set_ch1", bus.ovr, 2'b10);
    repeat (3) begin drive(1'b1, 1'b0, '0, 1'b0, safe); step(); end
    chk("ovr_sticky", bus.ovr, 2'b10);
    drive(1'b1, 1'b0, '0, 1'b0, {12'h555, 12'h000}); step();
    drive(1'b1, 1'b0, '0, 1'b1, safe); step();
    chk("ovr_set_wins", bus.ovr, 2'b01);
    drive(1'b1, 1'b0, '0, 1'b1, safe); step();
    drive(1'b1, 1'b0, '0, 1'b0, safe); step();
    chk("ovr_clr_alone", bus.ovr, 2'b00);
    drive(1'b0, 1'b0, '0, 1'b0, {12'hFFF, 12'hFFF}); step();
    drive(1'b0, 1'b0, '0, 1'b0, safe); step();
    step();
    chk("ovr_en_low", bus.ovr, 2'b00);

    // Reset mid-stream with dec=2, then the count restarts from zero.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'd2, 1'b0, {DW'(12'h200 + k), DW'(k)});
      step();
    end
    do_reset(2);
    got_q.delete();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 8'd2, 1'b0, {12'h000, DW'(50 + k)});
      step();
    end
    idle(2, 8'd2);
    exp_q = '{12'd52, 12'd55};
    cmp_queues("post_reset");

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 7))
          0:       rd[c*DW +: DW] = '0;
          1:       rd[c*DW +: DW] = '1;
          default: rd[c*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
        endcase
      end
      if ($urandom_range(0, 19) == 0) rf = ~rf;
      drive($urandom_range(0, 9) != 0, rf, DECW'($urandom_range(0, 4)),
            $urandom_range(0, 15) == 0, rd);
      step();
      if (i == 200) do_reset(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
# adc_capture

Parametrised multi-channel ADC sample capture block, the successor of the single 12-bit falling-edge data latch. It captures CH parallel ADC buses of DW bits on the falling clock edge, retimes them to the rising edge, optionally converts offset-binary to two's complement, and decimates by a runtime ratio. It also reports sticky per-channel overrange flags. It sits between the ADC pins and the sample processing chain.

## Interface
- DW, 12, sample width per channel (>=2)
- CH, 2, channel count
- DECW, 8, width of decimation ratio input
- clk  in  1  ADC sample clock; ADC data launched on rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  capture enable
- fmt  in  1  0 = pass raw (offset binary), 1 = two's complement (invert MSB)
- dec  in  DECW  decimation ratio minus one (0 = every sample)
- ovr_clr  in  1  clear all overrange flags
- datain  in  CH*DW  raw ADC buses, channel c at bits [c*DW +: DW]
- dataout  out  CH*DW  decimated, formatted samples, same packing
- dvalid  out  1  one-cycle strobe, dataout updated this cycle
- ovr  out  CH  sticky overrange flag per channel

## Operation
- Stage N (negedge clk): N <= datain, unconditionally.
- Stage R1 (posedge): r1_data <= per-channel fmt ? {~N[MSB], N[MSB-1:0]} : N; r1_v <= en; r1_or[c] <= raw N channel c == all-ones or all-zeros (detection on raw code, independent of fmt).
- Output stage (posedge), decimation counter cnt (DECW bits):
  - r1_v=0: cnt <= 0, dvalid <= 0, dataout holds.
  - r1_v=1 and cnt >= dec: dataout <= r1_data, dvalid <= 1, cnt <= 0.
  - r1_v=1 and cnt < dec: cnt <= cnt+1, dvalid <= 0, dataout holds.
- `>=` compare: dec lowered below current cnt mid-count wraps on next valid sample, no 2^DECW stall.
- dec=0: dvalid high every cycle while r1_v=1.
- First output after en rises is the first sample with r1_v=1 when dec=0, else the (dec+1)th.
- Overrange, per channel c: ovr[c] <= (ovr[c] & ~ovr_clr) | (r1_v & r1_or[c]); set wins over simultaneous clear. Set on every valid sample, not only decimated ones.
- fmt and dec are not synchronised; caller changes them only with en=0 or accepts one glitched sample.

## Timing
- Reset (async assert, release sync to clk by system): N, r1_data, r1_v, r1_or, cnt, dataout, dvalid, ovr all 0.
- Reset mid-operation: all state cleared immediately; no dvalid until r1_v=1 again after release.
- Latency: sample captured at falling edge between rising edges k and k+1 reaches r1 at edge k+1 and dataout/dvalid at edge k+2 (1.5 clk from capture).
- en is sampled at rising edge k+1, aligned with the sample captured at the preceding falling edge.
- ovr updates at the same edge as the corresponding dataout would (k+2).
- No backpressure; downstream must accept every dvalid strobe.
- Timing budget: datain setup/hold to falling edge; N-to-R1 path is half-cycle.

## Test plan
- Reset: assert rst mid-stream with dec=2 -> all outputs 0 asynchronously; after release with en=1, first dvalid 2 cycles after the third valid sample (count restarts at 0).
- Pass-through: CH=2, fmt=0, dec=0, en=1, ramp ch0=0x000.., ch1=0x100.. -> dataout equals input of each falling edge 1.5 clk later, dvalid constantly 1.
- Format: fmt=1, inputs 0x800, 0xFFF, 0x000, 0x7FF -> dataout 0x000, 0x7FF, 0x800, 0xFFF; fmt=0 returns raw codes.
- Decimation: dec=3, ramp 0,1,2,... -> dvalid every 4th cycle, dataout 3,7,11,...; change dec to 1 while cnt=2 -> next valid sample strobes, then period 2.
- Enable gating: drop en for 5 cycles mid-count with dec=3 -> no dvalid, dataout holds; on re-enable counting restarts, first strobe on 4th new sample.
- Overrange: ch1=0xFFF for one sample -> ovr=2'b10 and stays; ch0=0x000 with ovr_clr same cycle -> ovr=2'b01; ovr_clr alone -> ovr=0; 0xFFF with en=0 -> ovr unchanged.
